geig_packetizer: RTL

//   Downstream consumer of geig_data_handling. Captures each 48-bit G_DATA_STACK record on its strobe
//   and buffers records in a small FIFO. Frames each record into a 9-byte packet: sync, sequence,
//   6 data bytes MSB first, checksum. Emits the packet as a byte stream with valid/ready handshake

---
 rtl/geig_packetizer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/geig_packetizer.sv
// geig_packetizer: captures 48-bit Geiger records, buffers them in a small FIFO and
// streams each as a 9-byte packet (sync, sequence, 6 data bytes MSB first, checksum)
// over a valid/ready byte interface. Single clock domain (CLK_1MHZ).
//
// Build option: define GEIG_PKT_CRC8_EN to replace the mod-256 sum checksum with
// CRC-8 (poly 0x07, init 0x00, unreflected, no final xor) over the same 7 bytes.
// Framing, timing and ports are identical in both builds.
module geig_packetizer #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SYNC_BYTE  = 8'h47
) (
    input  logic                          CLK_1MHZ,
    input  logic                          RESET,
    input  logic [47:0]                   G_DATA_STACK,
    input  logic                          STACK_STROBE,
    output logic [7:0]                    BYTE_OUT,
    output logic                          BYTE_VALID,
    input  logic                          BYTE_READY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
    output logic [7:0]                    DROP_COUNT,
    output logic                          BUSY
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_SEQ,
        ST_DATA,
        ST_CHK
    } state_t;

    // Running checksum update for one transferred byte.
    function automatic logic [7:0] chk_acc(input logic [7:0] acc, input logic [7:0] b);
`ifdef GEIG_PKT_CRC8_EN
        logic [7:0] c;
        c = acc ^ b;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
`else
        return acc + b;
`endif
    endfunction

    // Data byte k of a record, MSB first.
    function automatic logic [7:0] data_byte(input logic [47:0] rec, input logic [2:0] k);
        case (k)
            3'd0:    return rec[47:40];
            3'd1:    return rec[39:32];
            3'd2:    return rec[31:24];
            3'd3:    return rec[23:16];
            3'd4:    return rec[15:8];
            default: return rec[7:0];
        endcase
    endfunction

    // Stage p0: strobe capture register
    logic [47:0]   rec_p0;
    logic          vld_p0;

    // FIFO storage and control
    logic [47:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic [7:0]    drop_cnt;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          drop;

    // Stage p1: packet FSM and transmit datapath
    state_t        state;
    logic [7:0]    seq;
    logic [2:0]    byte_idx;
    logic [47:0]   tx_rec;
    logic [7:0]    chk;
    logic          xfer;

    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LW'(FIFO_DEPTH));
    assign xfer       = BYTE_VALID & BYTE_READY;

    // A record leaves the FIFO when a packet starts from IDLE or chains directly after CHK.
    assign pop  = !fifo_empty && ((state == ST_IDLE) || ((state == ST_CHK) && xfer));
    assign push = vld_p0 && (!fifo_full || pop);
    assign drop = vld_p0 && fifo_full && !pop;

    assign FIFO_LEVEL = level;
    assign DROP_COUNT = drop_cnt;
    assign BUSY       = (state != ST_IDLE);

    // Strobe valid flag for the capture stage.
    always_ff @(posedge CLK_1MHZ) begin
        if (RESET) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= STACK_STROBE;
        end
    end

    // Record capture, loaded only on a strobe.
    always_ff @(posedge CLK_1MHZ) begin
        if (STACK_STROBE) begin
            rec_p0 <= G_DATA_STACK;
        end
    end

    // FIFO storage write.
    always_ff @(posedge CLK_1MHZ) begin
        if (push) begin
            fifo_mem[wr_ptr] <= rec_p0;
        end
    end

    // FIFO pointers, occupancy and saturating overflow counter.
    always_ff @(posedge CLK_1MHZ) begin
        if (RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            drop_cnt <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Shadow copy of the record being transmitted, taken at pop time.
    always_ff @(posedge CLK_1MHZ) begin
        if (pop) begin
            tx_rec <= fifo_mem[rd_ptr];
        end
    end

    // Checksum accumulator: cleared at packet start, updated as SEQ and data bytes transfer.
    always_ff @(posedge CLK_1MHZ) begin
        if (pop) begin
            chk <= 8'd0;
        end else if (xfer && ((state == ST_SEQ) || (state == ST_DATA))) begin
            chk <= chk_acc(chk, BYTE_OUT);
        end
    end

    // Packet FSM with registered byte output; each state advances only on a transfer.
    always_ff @(posedge CLK_1MHZ) begin
        if (RESET) begin
            state      <= ST_IDLE;
            seq        <= 8'd0;
            byte_idx   <= 3'd0;
            BYTE_OUT   <= 8'h00;
            BYTE_VALID <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state      <= ST_SYNC;
                        BYTE_OUT   <= SYNC_BYTE;
                        BYTE_VALID <= 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (xfer) begin
                        state    <= ST_SEQ;
                        BYTE_OUT <= seq;
                    end
                end
                ST_SEQ: begin
                    if (xfer) begin
                        state    <= ST_DATA;
                        byte_idx <= 3'd0;
                        BYTE_OUT <= data_byte(tx_rec, 3'd0);
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        if (byte_idx == 3'd5) begin
                            state    <= ST_CHK;
                            BYTE_OUT <= chk_acc(chk, BYTE_OUT);
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            BYTE_OUT <= data_byte(tx_rec, byte_idx + 3'd1);
                        end
                    end
                end
                ST_CHK: begin
                    if (xfer) begin
                        seq <= seq + 8'd1;
                        if (!fifo_empty) begin
                            state    <= ST_SYNC;
                            BYTE_OUT <= SYNC_BYTE;
                        end else begin
                            state      <= ST_IDLE;
                            BYTE_OUT   <= 8'h00;
                            BYTE_VALID <= 1'b0;
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    BYTE_VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule
